sisc_core_p: RTL and testbench
==============================

# sisc_core_p

Parametrised multi-cycle SISC execution core: accepts one 32-bit instruction at a time over a valid/ready handshake, runs it through a fetch/decode/execute/writeback state machine, and owns its register file, ALU and status register. Successor to the part-1 top; adds configurable data width and register count, an immediate ALU path, a compare instruction, HALT, and per-write observability ports for the bench.

## Interface
- DW, 32: datapath width; legal 8..64.
- NREG, 16: register count; legal 2..16; AW = $clog2(NREG).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- ir  in  32  instruction: [31:28] op, [27:24] mm, [23:20] rd, [19:16] rs, [15:12] rt, [15:0] imm.
- ir_valid  in  1  instruction present on ir.
- ir_ready  out  1  core can accept; high only in FETCH and rst low.
- stat  out  4  {C,V,N,Z}, bit 3 = carry.
- halted  out  1  high in HALT state.
- wb_valid  out  1  one-cycle pulse when a register is written.
- wb_addr  out  AW  register written.
- wb_data  out  DW  value written.
- dbg_addr  in  AW  debug read address.
- dbg_data  out  DW  combinational register read (r0 reads 0).

## Operation
- Reset: state FETCH, all registers 0, stat 0000, latched IR 0, halted 0, wb_valid 0.
- States: FETCH -> DECODE on ir_valid&&ir_ready (ir latched); DECODE -> EXEC; EXEC -> WB; WB -> FETCH; DECODE of op F -> HALT. HALT exits only via rst.
- r0 reads zero; writes to r0 dropped (no wb_valid). rd/rs/rt >= NREG read 0, writes dropped.
- Ops: 0 NOP; 1 ALU rs op rt -> rd; 2 ALU rs op sext(imm) -> rd (imm truncated to DW if DW<16); 3 CMP: SUB rs-rt, flags only; F HALT; others = NOP (no flags, no write).
- mm functions: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT rs, 6 SHL1 rs, 7 SHR1 rs (logical), 8 ADC (rs+op2+C); 9..F: no write, flags unchanged.
- Arithmetic at DW+1 bits. C = bit DW of sum; SUB/CMP computed as rs + ~op2 + 1 (C=1 means no borrow). V = signed overflow. N = result[DW-1], Z = result==0.
- Flag update: ADD/SUB/ADC/CMP all four; AND/OR/XOR/NOT N,Z only; SHL1/SHR1 C = shifted-out bit, N,Z updated, V held.
- stat updated at end of EXEC; ADC uses C as held at start of EXEC.

## Timing
- Instruction accepted at edge E; operands read E+1; result and stat registered at E+2; register written at E+3 with wb_valid/addr/data high in the cycle before that edge (WB state).
- ir_ready high again in the cycle after E+3; throughput one instruction per 4 cycles.
- ir_valid outside FETCH ignored; ir not required stable after acceptance.
- rst wins over everything: asserted in any state aborts the instruction with no register write, clears all state; ir_ready rises the first cycle with rst low.
- HALT: ir_ready 0, halted 1 from the cycle after DECODE onward.

## Structure
- Package sisc_pkg: opcode constants, mm function codes, stat bit indexes (C=3,V=2,N=1,Z=0), state encoding typedef.
- Sub-module sisc_alu_p (parameter DW): combinational ALU returning result and four flags plus flag-enable mask. Register file and FSM inline in sisc_core_p.

## Test plan
- DW=32: rst, then 0x20100005 (ADDI r1,r0,5) -> wb_valid, wb_addr 1, wb_data 0x00000005 in cycle before E+3; stat 0000.
- 0x2020FFFF -> r2 = 0xFFFFFFFF, stat N=1 (0010); then 0x10321000 (ADD r3=r2+r1) -> r3 = 4, stat 1000.
- 0x18400000 (ADC r4=r0+r0 with C=1) -> r4 = 1; then 0x30011000 (CMP r1,r1) -> stat 1001, no wb_valid.
- Hold ir_valid low 5 cycles -> no writes, ir_ready stays 1; pulse ir_valid during EXEC -> ignored, dbg_data unchanged.
- DW=8, NREG=4: ADDI r1,r0,0x7F then ADDI r1,r1,1 -> r1 = 0x80, V=1, N=1; ADDI with rd=5 -> no write.
- 0xF0000000 -> halted 1, ir_ready 0 with ir_valid held high; rst in EXEC of an ADDI -> no write, all dbg reads 0, ir_ready 1 cycle after rst drops.

Source files
------------

// File: rtl/sisc_pkg.sv
// sisc_pkg: shared constants and types for the SISC core.
// Opcodes, ALU function codes, stat bit positions, FSM state encodings.
package sisc_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_ALUI = 4'h2;
  localparam logic [3:0] OP_CMP  = 4'h3;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] FN_ADD = 4'h0;
  localparam logic [3:0] FN_SUB = 4'h1;
  localparam logic [3:0] FN_AND = 4'h2;
  localparam logic [3:0] FN_OR  = 4'h3;
  localparam logic [3:0] FN_XOR = 4'h4;
  localparam logic [3:0] FN_NOT = 4'h5;
  localparam logic [3:0] FN_SHL = 4'h6;
  localparam logic [3:0] FN_SHR = 4'h7;
  localparam logic [3:0] FN_ADC = 4'h8;

  localparam int ST_C = 3;
  localparam int ST_V = 2;
  localparam int ST_N = 1;
  localparam int ST_Z = 0;

  typedef logic [2:0] state_t;

  localparam state_t S_FETCH  = 3'd0;
  localparam state_t S_DECODE = 3'd1;
  localparam state_t S_EXEC   = 3'd2;
  localparam state_t S_WB     = 3'd3;
  localparam state_t S_HALT   = 3'd4;

  // lo holds imm[15:0]; rt overlays lo[15:12]
  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  mm;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [15:0] lo;
  } instr_t;

  function automatic logic [3:0] rt_of(instr_t i);
    return i.lo[15:12];
  endfunction

endpackage

// File: rtl/sisc_alu_p.sv
// sisc_alu_p: combinational ALU for the SISC core.
// Ports: fn, a, b, cin in; res, flags {C,V,N,Z}, mask (flags to update), wr out.
module sisc_alu_p
  import sisc_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [3:0]    fn,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          cin,
  output logic [DW-1:0] res,
  output logic [3:0]    flags,
  output logic [3:0]    mask,
  output logic          wr
);

  logic [DW-1:0] b2;
  logic          ci;
  logic [DW:0]   sum;
  logic          ov;
  logic          c;

  // SUB is a + ~b + 1 so carry means "no borrow"
  assign b2  = (fn == FN_SUB) ? ~b : b;
  assign ci  = (fn == FN_SUB) ? 1'b1
             : (fn == FN_ADC) ? cin : 1'b0;
  assign sum = {1'b0, a} + {1'b0, b2}
             + {{DW{1'b0}}, ci};
  assign ov  = (a[DW-1] == b2[DW-1])
             && (sum[DW-1] != a[DW-1]);

  always_comb begin
    res  = '0;
    c    = 1'b0;
    mask = 4'b0000;
    wr   = 1'b0;
    unique case (fn)
      FN_ADD, FN_SUB, FN_ADC: begin
        res  = sum[DW-1:0];
        c    = sum[DW];
        mask = 4'b1111;
        wr   = 1'b1;
      end
      FN_AND: begin
        res  = a & b;
        mask = 4'b0011;
        wr   = 1'b1;
      end
      FN_OR: begin
        res  = a | b;
        mask = 4'b0011;
        wr   = 1'b1;
      end
      FN_XOR: begin
        res  = a ^ b;
        mask = 4'b0011;
        wr   = 1'b1;
      end
      FN_NOT: begin
        res  = ~a;
        mask = 4'b0011;
        wr   = 1'b1;
      end
      FN_SHL: begin
        res  = {a[DW-2:0], 1'b0};
        c    = a[DW-1];
        mask = 4'b1011;
        wr   = 1'b1;
      end
      FN_SHR: begin
        res  = {1'b0, a[DW-1:1]};
        c    = a[0];
        mask = 4'b1011;
        wr   = 1'b1;
      end
      default: begin
        res  = '0;
      end
    endcase
  end

  assign flags = {c, ov, res[DW-1], res == '0};

endmodule

// File: rtl/sisc_core_p.sv
// sisc_core_p: multi-cycle SISC core (FETCH/DECODE/EXEC/WB/HALT).
// Ports: clk, rst, ir/ir_valid/ir_ready, stat, halted, wb_*, dbg_addr/dbg_data.
module sisc_core_p
  import sisc_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NREG = 16,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   ir,
  input  logic          ir_valid,
  output logic          ir_ready,
  output logic [3:0]    stat,
  output logic          halted,
  output logic          wb_valid,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  localparam logic [4:0] NREG5 = 5'(NREG);

  state_t        state;
  instr_t        ir_q;
  logic [DW-1:0] rf [NREG];
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [DW-1:0] res_q;
  logic          wr_q;
  logic [AW-1:0] wa_q;

  logic [DW-1:0] imm_ext;
  logic [3:0]    alu_fn;
  logic [DW-1:0] alu_res;
  logic [3:0]    alu_flags;
  logic [3:0]    alu_mask;
  logic          alu_wr;
  logic          is_alu;
  logic          is_cmp;

  // r0 and addresses past the register count are not real registers
  function automatic logic in_range(logic [3:0] a);
    return (a != 4'd0) && ({1'b0, a} < NREG5);
  endfunction

  function automatic logic [DW-1:0] rd_reg(logic [3:0] a);
    return in_range(a) ? rf[a[AW-1:0]] : '0;
  endfunction

  // signed size cast sign-extends for DW>16, truncates for DW<16
  assign imm_ext = DW'($signed(ir_q.lo));

  assign is_alu = (ir_q.op == OP_ALU)
               || (ir_q.op == OP_ALUI);
  assign is_cmp = (ir_q.op == OP_CMP);
  assign alu_fn = is_cmp ? FN_SUB : ir_q.mm;

  sisc_alu_p #(.DW(DW)) u_alu (
    .fn    (alu_fn),
    .a     (op_a),
    .b     (op_b),
    .cin   (stat[ST_C]),
    .res   (alu_res),
    .flags (alu_flags),
    .mask  (alu_mask),
    .wr    (alu_wr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      ir_q  <= '0;
      stat  <= 4'b0000;
      op_a  <= '0;
      op_b  <= '0;
      res_q <= '0;
      wr_q  <= 1'b0;
      wa_q  <= '0;
      for (int i = 0; i < NREG; i++)
        rf[i] <= '0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (ir_valid) begin
            ir_q  <= instr_t'(ir);
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          op_a <= rd_reg(ir_q.rs);
          op_b <= (ir_q.op == OP_ALUI)
                ? imm_ext
                : rd_reg(rt_of(ir_q));
          state <= (ir_q.op == OP_HALT)
                 ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          if (is_alu || is_cmp)
            stat <= (stat & ~alu_mask)
                  | (alu_flags & alu_mask);
          res_q <= alu_res;
          wa_q  <= ir_q.rd[AW-1:0];
          wr_q  <= is_alu && alu_wr
                && in_range(ir_q.rd);
          state <= S_WB;
        end
        S_WB: begin
          if (wr_q)
            rf[wa_q] <= res_q;
          state <= S_FETCH;
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

  assign ir_ready = (state == S_FETCH) && !rst;
  assign halted   = (state == S_HALT);
  assign wb_valid = (state == S_WB) && wr_q;
  assign wb_addr  = wa_q;
  assign wb_data  = res_q;
  assign dbg_data = rd_reg(4'(dbg_addr));

endmodule

// File: tb/tb_sisc_core_p.sv
// tb_sisc_core_p: scoreboard bench for sisc_core_p.
// Two instances: DW=32/NREG=16 (a) and DW=8/NREG=4 (b).
module tb_sisc_core_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1;
  logic [31:0] ir_a = '0;
  logic        irv_a = 1'b0;
  logic        rdy_a;
  logic [3:0]  stat_a;
  logic        hlt_a;
  logic        wbv_a;
  logic [3:0]  wba_a;
  logic [31:0] wbd_a;
  logic [3:0]  dba_a = '0;
  logic [31:0] dbd_a;

  logic        rst_b = 1'b1;
  logic [31:0] ir_b = '0;
  logic        irv_b = 1'b0;
  logic        rdy_b;
  logic [3:0]  stat_b;
  logic        hlt_b;
  logic        wbv_b;
  logic [1:0]  wba_b;
  logic [7:0]  wbd_b;
  logic [1:0]  dba_b = '0;
  logic [7:0]  dbd_b;

  sisc_core_p #(.DW(32), .NREG(16)) u_a (
    .clk(clk), .rst(rst_a),
    .ir(ir_a), .ir_valid(irv_a),
    .ir_ready(rdy_a), .stat(stat_a),
    .halted(hlt_a), .wb_valid(wbv_a),
    .wb_addr(wba_a), .wb_data(wbd_a),
    .dbg_addr(dba_a), .dbg_data(dbd_a)
  );

  sisc_core_p #(.DW(8), .NREG(4)) u_b (
    .clk(clk), .rst(rst_b),
    .ir(ir_b), .ir_valid(irv_b),
    .ir_ready(rdy_b), .stat(stat_b),
    .halted(hlt_b), .wb_valid(wbv_b),
    .wb_addr(wba_b), .wb_data(wbd_b),
    .dbg_addr(dba_b), .dbg_data(dbd_b)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  a;
    logic [63:0] d;
  } wbe_t;

  wbe_t qa[$];
  wbe_t qb[$];

  always @(negedge clk) begin
    if (wbv_a) begin
      if (qa.size() == 0) begin
        chk("a_wb_extra", 64'(wba_a), 64'hF0);
      end else begin
        wbe_t e;
        e = qa.pop_front();
        chk("a_wb_addr", 64'(wba_a), 64'(e.a));
        chk("a_wb_data", 64'(wbd_a), e.d);
      end
    end
    if (wbv_b) begin
      if (qb.size() == 0) begin
        chk("b_wb_extra", 64'(wba_b), 64'hF0);
      end else begin
        wbe_t e;
        e = qb.pop_front();
        chk("b_wb_addr", 64'(wba_b), 64'(e.a));
        chk("b_wb_data", 64'(wbd_b), e.d);
      end
    end
  end

  function automatic logic rdy(input bit b);
    return b ? rdy_b : rdy_a;
  endfunction

  task automatic issue(input bit b,
                       input logic [31:0] ins);
    int n = 0;
    @(negedge clk);
    while (!rdy(b) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("issue_rdy", 64'(rdy(b)), 64'd1);
    if (b) begin
      ir_b = ins;
      irv_b = 1'b1;
    end else begin
      ir_a = ins;
      irv_a = 1'b1;
    end
    @(posedge clk);
    #1;
    irv_a = 1'b0;
    irv_b = 1'b0;
  endtask

  task automatic wait_rdy(input bit b);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy(b) && n < 20);
    chk("done_rdy", 64'(rdy(b)), 64'd1);
  endtask

  task automatic run(input string tag,
                     input bit b,
                     input logic [31:0] ins,
                     input bit w,
                     input logic [3:0] wa,
                     input logic [63:0] wd,
                     input logic [3:0] st);
    wbe_t e;
    e.a = wa;
    e.d = wd;
    if (w) begin
      if (b) qb.push_back(e);
      else   qa.push_back(e);
    end
    issue(b, ins);
    wait_rdy(b);
    chk(tag, 64'(b ? stat_b : stat_a),
        64'(st));
  endtask

  task automatic peek(input string tag,
                      input bit b,
                      input logic [3:0] a,
                      input logic [63:0] exp);
    if (b) dba_b = a[1:0];
    else   dba_a = a;
    #1;
    chk(tag, b ? 64'(dbd_b) : 64'(dbd_a), exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", 64'(rdy_a), 64'd0);
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    chk("rst_rdy_up", 64'(rdy_a), 64'd1);
    chk("rst_stat", 64'(stat_a), 64'd0);
    chk("rst_halt", 64'(hlt_a), 64'd0);
    chk("rst_wbv", 64'(wbv_a), 64'd0);
    peek("rst_r1", 0, 4'd1, 64'd0);

    // first ADDI with exact writeback timing
    qa.push_back('{4'd1, 64'd5});
    issue(0, 32'h20100005);
    @(negedge clk);
    chk("t_dec_rdy", 64'(rdy_a), 64'd0);
    @(negedge clk);
    chk("t_exe_wbv", 64'(wbv_a), 64'd0);
    @(negedge clk);
    chk("t_wb_wbv", 64'(wbv_a), 64'd1);
    wait_rdy(0);
    chk("addi_st", 64'(stat_a), 64'h0);

    run("neg_st", 0, 32'h2020FFFF, 1,
        4'd2, 64'hFFFFFFFF, 4'b0010);
    run("add_st", 0, 32'h10321000, 1,
        4'd3, 64'd4, 4'b1000);
    run("adc_st", 0, 32'h18400000, 1,
        4'd4, 64'd1, 4'b0000);
    run("cmp_st", 0, 32'h30011000, 0,
        4'd0, 64'd0, 4'b1001);
    run("and_st", 0, 32'h12831000, 1,
        4'd8, 64'd4, 4'b1000);
    run("shl_st", 0, 32'h16920000, 1,
        4'd9, 64'hFFFFFFFE, 4'b1010);
    run("shr_st", 0, 32'h17A10000, 1,
        4'd10, 64'd2, 4'b1000);
    run("not_st", 0, 32'h15B30000, 1,
        4'd11, 64'hFFFFFFFB, 4'b1010);
    run("or_st", 0, 32'h13C13000, 1,
        4'd12, 64'd5, 4'b1000);
    run("sub_st", 0, 32'h11DA1000, 1,
        4'd13, 64'hFFFFFFFD, 4'b0010);
    run("mm9_st", 0, 32'h19E10000, 0,
        4'd0, 64'd0, 4'b0010);
    run("op5_st", 0, 32'h5F110000, 0,
        4'd0, 64'd0, 4'b0010);
    run("r0w_st", 0, 32'h20010003, 0,
        4'd0, 64'd0, 4'b0000);
    peek("r3", 0, 4'd3, 64'd4);
    peek("r9", 0, 4'd9, 64'hFFFFFFFE);
    peek("r13", 0, 4'd13, 64'hFFFFFFFD);
    peek("r0", 0, 4'd0, 64'd0);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_rdy", 64'(rdy_a), 64'd1);
    end

    // ir_valid pulsed while busy must be ignored
    qa.push_back('{4'd5, 64'd7});
    issue(0, 32'h20500007);
    @(negedge clk);
    @(negedge clk);
    ir_a = 32'h20600009;
    irv_a = 1'b1;
    @(posedge clk);
    #1;
    irv_a = 1'b0;
    wait_rdy(0);
    chk("pulse_st", 64'(stat_a), 64'd0);
    peek("pulse_r6", 0, 4'd6, 64'd0);
    peek("pulse_r5", 0, 4'd5, 64'd7);

    // narrow instance
    run("b_7f_st", 1, 32'h2010007F, 1,
        4'd1, 64'h7F, 4'b0000);
    run("b_ov_st", 1, 32'h20110001, 1,
        4'd1, 64'h80, 4'b0110);
    run("b_rd5_st", 1, 32'h20510001, 0,
        4'd0, 64'd0, 4'b0010);
    run("b_rs5_st", 1, 32'h20250003, 1,
        4'd2, 64'd3, 4'b0000);
    peek("b_r1", 1, 4'd1, 64'h80);
    peek("b_r2", 1, 4'd2, 64'd3);
    peek("b_r3", 1, 4'd3, 64'd0);

    // HALT with ir_valid held high afterwards
    issue(0, 32'hF0000000);
    @(negedge clk);
    chk("h_dec", 64'(hlt_a), 64'd0);
    ir_a = 32'h20100005;
    irv_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("h_halt", 64'(hlt_a), 64'd1);
      chk("h_rdy", 64'(rdy_a), 64'd0);
    end
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    irv_a = 1'b0;
    @(negedge clk);
    chk("h_rst_rdy", 64'(rdy_a), 64'd0);
    chk("h_rst_hlt", 64'(hlt_a), 64'd0);
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    @(negedge clk);
    chk("h_up_rdy", 64'(rdy_a), 64'd1);

    // reset during EXEC aborts the write
    run("pre_st", 0, 32'h20100009, 1,
        4'd1, 64'd9, 4'b0000);
    issue(0, 32'h20200003);
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("x_rdy_rst", 64'(rdy_a), 64'd0);
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    @(negedge clk);
    chk("x_rdy_up", 64'(rdy_a), 64'd1);
    chk("x_stat", 64'(stat_a), 64'd0);
    for (int i = 0; i < 16; i++)
      peek("x_dbg", 0, 4'(i), 64'd0);
    repeat (6) @(negedge clk);

    chk("qa_empty", 64'(qa.size()), 64'd0);
    chk("qb_empty", 64'(qb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
